// File: rtl/tlc_pkg.sv
// Shared types for the multi-phase traffic light controller: state encoding
// and the phase-index width helper.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10,
        ST_FLASH  = 2'b11
    } state_t;

    function automatic int phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlc_phase_picker.sv
// Round-robin phase selection: next requesting phase after cur (cur itself last),
// plus a flag telling whether any phase other than cur is waiting.
module tlc_phase_picker
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int PW         = phase_w(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] i_req,
    input  logic [PW-1:0]         i_cur,
    output logic [PW-1:0]         o_next_phase,
    output logic                  o_any_other
);

    int   w_idx;
    logic w_found;

    // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        o_next_phase = i_cur;
        o_any_other  = |(i_req & ~(NUM_PHASES'(1) << i_cur));
        w_found      = 1'b0;
        w_idx        = 0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            w_idx = (int'(i_cur) + k) % NUM_PHASES;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_next_phase = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// Multi-phase traffic light controller: tick-timed GREEN/YELLOW/ALLRED cycle with
// latched demand, round-robin skipping, green extension and maintenance flash.
module traffic_light_ctrl_n
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int GREEN_MIN   = 5,
    parameter int GREEN_MAX   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int CNT_W       = 8
) (
    input  logic                             Clk_i,
    input  logic                             nReset_i,
    input  logic                             Tick_i,
    input  logic [NUM_PHASES-1:0]            Car_i,
    input  logic                             Flash_i,
    output logic [NUM_PHASES-1:0]            Green_o,
    output logic [NUM_PHASES-1:0]            Yellow_o,
    output logic [NUM_PHASES-1:0]            Red_o,
    output logic [phase_w(NUM_PHASES)-1:0]   Phase_o,
    output logic [1:0]                       State_o
);

    localparam int PW = phase_w(NUM_PHASES);
    localparam logic [CNT_W-1:0] C_GMIN   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(ALLRED_TIME - 1);

    state_t                  r_state;
    logic [PW-1:0]           r_cur;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_PHASES-1:0]   r_req;
    logic                    r_blink;

    logic [PW-1:0]           w_next_phase;
    logic                    w_any_other;
    logic                    w_green_exit;
    logic                    w_enter_green;
    logic [NUM_PHASES-1:0]   w_req_set;
    logic [NUM_PHASES-1:0]   w_req_clr;
    logic [NUM_PHASES-1:0]   w_req_next;

    tlc_phase_picker #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_picker (
        .i_req        (r_req),
        .i_cur        (r_cur),
        .o_next_phase (w_next_phase),
        .o_any_other  (w_any_other)
    );

    // Served phase's own sensor extends green up to GREEN_MAX while others wait.
    assign w_green_exit  = (r_cnt >= C_GMIN) && w_any_other &&
                           (!Car_i[r_cur] || (r_cnt >= C_GMAX));
    assign w_enter_green = (r_state == ST_ALLRED) && Tick_i && !Flash_i &&
                           (r_cnt == C_ALLRED);

    always_comb begin
        w_req_set = Car_i;
        w_req_clr = '0;
        if (r_state == ST_GREEN) w_req_set[r_cur] = 1'b0;
        if (w_enter_green)       w_req_clr[w_next_phase] = 1'b1;
        w_req_next = (r_req | w_req_set) & ~w_req_clr;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge Clk_i) begin
        if (!nReset_i) begin
            r_state <= ST_ALLRED;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_req   <= '0;
            r_blink <= 1'b0;
        end else begin
            r_req <= w_req_next;
            if (Flash_i && (r_state != ST_FLASH)) begin
                r_state <= ST_FLASH;
                r_cnt   <= '0;
                r_blink <= 1'b0;
            end else begin
                case (r_state)
                    ST_FLASH: begin
                        if (!Flash_i) begin
                            r_state <= ST_ALLRED;
                            r_cnt   <= '0;
                            r_blink <= 1'b0;
                        end else if (Tick_i) begin
                            r_blink <= ~r_blink;
                        end
                    end
                    ST_GREEN: begin
                        if (Tick_i) begin
                            if (w_green_exit) begin
                                r_state <= ST_YELLOW;
                                r_cnt   <= '0;
                            end else if (r_cnt < C_GMAX) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_YELLOW: begin
                        if (Tick_i) begin
                            if (r_cnt == C_YELLOW) begin
                                r_state <= ST_ALLRED;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_ALLRED: begin
                        if (Tick_i) begin
                            if (r_cnt == C_ALLRED) begin
                                r_state <= ST_GREEN;
                                r_cur   <= w_next_phase;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        Green_o  = '0;
        Yellow_o = '0;
        Red_o    = '1;
        case (r_state)
            ST_GREEN: begin
                Green_o[r_cur] = 1'b1;
                Red_o[r_cur]   = 1'b0;
            end
            ST_YELLOW: begin
                Yellow_o[r_cur] = 1'b1;
                Red_o[r_cur]    = 1'b0;
            end
            ST_FLASH: begin
                Red_o    = '0;
                Yellow_o = {NUM_PHASES{r_blink}};
            end
            default: ;
        endcase
    end

    assign Phase_o = r_cur;
    assign State_o = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Bench for traffic_light_ctrl_n: directed scenarios plus randomized traffic,
// every cycle compared against a countdown-based behavioural model.
module tb_traffic_light_ctrl_n;

    localparam int N           = 4;
    localparam int GREEN_MIN   = 5;
    localparam int GREEN_MAX   = 20;
    localparam int YELLOW_TIME = 3;
    localparam int ALLRED_TIME = 2;

    logic       clk = 1'b0;
    logic       nrst;
    logic       tick;
    logic       flash;
    logic [3:0] car;
    logic [3:0] green, yellow, red;
    logic [1:0] phase;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_ctrl_n #(
        .NUM_PHASES  (N),
        .GREEN_MIN   (GREEN_MIN),
        .GREEN_MAX   (GREEN_MAX),
        .YELLOW_TIME (YELLOW_TIME),
        .ALLRED_TIME (ALLRED_TIME),
        .CNT_W       (8)
    ) dut (
        .Clk_i    (clk),
        .nReset_i (nrst),
        .Tick_i   (tick),
        .Car_i    (car),
        .Flash_i  (flash),
        .Green_o  (green),
        .Yellow_o (yellow),
        .Red_o    (red),
        .Phase_o  (phase),
        .State_o  (state)
    );

    always #5 clk = ~clk;

    // Reference model: green time counted up in served ticks, yellow/all-red as remaining ticks.
    typedef enum int {M_GO, M_CAUTION, M_CLEAR, M_MAINT} mode_e;
    mode_e  m_mode  = M_CLEAR;
    int     m_cur   = 0;
    bit [3:0] m_req = '0;
    int     m_left  = ALLRED_TIME;
    int     m_gt    = 0;
    bit     m_blink = 1'b0;

    task automatic model_step();
        bit [3:0] nreq;
        bit       others;
        bit       found;
        int       p;
        if (!nrst) begin
            m_mode = M_CLEAR; m_cur = 0; m_req = '0;
            m_left = ALLRED_TIME; m_gt = 0; m_blink = 1'b0;
            return;
        end
        nreq = m_req;
        for (int i = 0; i < N; i++)
            if (car[i] && !(m_mode == M_GO && m_cur == i)) nreq[i] = 1'b1;
        if (flash && m_mode != M_MAINT) begin
            m_mode  = M_MAINT;
            m_blink = 1'b0;
        end else begin
            case (m_mode)
                M_MAINT: begin
                    if (!flash) begin
                        m_mode = M_CLEAR; m_left = ALLRED_TIME; m_blink = 1'b0;
                    end else if (tick) begin
                        m_blink = !m_blink;
                    end
                end
                M_GO: if (tick) begin
                    m_gt++;
                    others = 1'b0;
                    for (int i = 0; i < N; i++) if (i != m_cur && m_req[i]) others = 1'b1;
                    if (m_gt >= GREEN_MIN && others && (!car[m_cur] || m_gt >= GREEN_MAX)) begin
                        m_mode = M_CAUTION; m_left = YELLOW_TIME;
                    end
                end
                M_CAUTION: if (tick) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_CLEAR; m_left = ALLRED_TIME; end
                end
                M_CLEAR: if (tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            p = (m_cur + k) % N;
                            if (!found && m_req[p]) begin found = 1'b1; m_cur = p; end
                        end
                        m_mode = M_GO; m_gt = 0; nreq[m_cur] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        m_req = nreq;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [1:0] mode_code(input mode_e m);
        case (m)
            M_GO:      return 2'd0;
            M_CAUTION: return 2'd1;
            M_CLEAR:   return 2'd2;
            default:   return 2'd3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg, ey, er;
        for (int p = 0; p < N; p++) begin
            eg[p] = (m_mode == M_GO && m_cur == p);
            ey[p] = (m_mode == M_CAUTION && m_cur == p) || (m_mode == M_MAINT && m_blink);
            er[p] = (m_mode == M_CLEAR) || ((m_mode == M_GO || m_mode == M_CAUTION) && m_cur != p);
        end
        check("mdl_green",  green,  eg);
        check("mdl_yellow", yellow, ey);
        check("mdl_red",    red,    er);
        check("mdl_phase",  phase,  m_cur);
        check("mdl_state",  state,  mode_code(m_mode));
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_state(input logic [1:0] code, input int limit, input string tag);
        int n = 0;
        while (state !== code && n < limit) begin
            cycle();
            n++;
        end
        check(tag, state, code);
    endtask

    initial begin
        nrst = 1'b0; tick = 1'b1; car = '0; flash = 1'b0;
        cycle(); cycle();
        nrst = 1'b1;

        // 1: reset state, two all-red ticks, then phase 0 rests in green
        check("t1_rst_red",   red,   4'b1111);
        check("t1_rst_green", green, 4'b0000);
        check("t1_rst_phase", phase, 0);
        check("t1_rst_state", state, 2'b10);
        cycle();
        check("t1_allred2", red, 4'b1111);
        cycle();
        check("t1_green0", green, 4'b0001);
        repeat (55) cycle();
        check("t1_rest_green", green, 4'b0001);
        check("t1_rest_phase", phase, 0);

        // 2: demand on phase 2 skips phase 1
        car = 4'b0100; cycle();
        car = 4'b0000; cycle();
        check("t2_yellow_1", yellow, 4'b0001);
        cycle(); cycle();
        check("t2_yellow_3", yellow, 4'b0001);
        cycle();
        check("t2_allred_1", state, 2'b10);
        cycle();
        check("t2_allred_2", red, 4'b1111);
        cycle();
        check("t2_green2", green, 4'b0100);
        check("t2_phase2", phase, 2);

        // 3: own sensor held extends green to GREEN_MAX
        car = 4'b0110; cycle();
        car = 4'b0100; repeat (18) cycle();
        check("t3_ext_green", green, 4'b0100);
        cycle();
        check("t3_max_yellow", yellow, 4'b0100);
        car = 4'b0000;
        repeat (3) cycle();
        check("t3_allred", state, 2'b10);
        repeat (2) cycle();
        check("t3_green1", green, 4'b0010);
        check("t3_phase1", phase, 1);

        // 4: flash entered mid-yellow, then released
        car = 4'b1000; cycle();
        car = 4'b0000;
        wait_state(2'b01, 30, "t4_wait_yellow");
        cycle();
        flash = 1'b1; cycle();
        check("t4_flash_state", state, 2'b11);
        check("t4_flash_red",   red,   4'b0000);
        check("t4_blink0",      yellow, 4'b0000);
        cycle();
        check("t4_blink1", yellow, 4'b1111);
        cycle();
        check("t4_blink2", yellow, 4'b0000);
        flash = 1'b0; cycle();
        check("t4_rel_allred", state, 2'b10);
        cycle(); cycle();
        check("t4_rel_green3", green, 4'b1000);
        flash = 1'b1; cycle();
        check("t4_flash_from_green", state, 2'b11);
        repeat (4) cycle();
        flash = 1'b0; cycle();
        check("t4_rel2_allred", state, 2'b10);
        cycle(); cycle();
        check("t4_rel2_same_phase", green, 4'b1000);
        check("t4_rel2_phase", phase, 3);

        // 5: reset during green of phase 3 drops latched demand
        car = 4'b0011; cycle();
        car = 4'b0000; nrst = 1'b0; cycle();
        nrst = 1'b1;
        check("t5_red",    red,    4'b1111);
        check("t5_green",  green,  4'b0000);
        check("t5_yellow", yellow, 4'b0000);
        check("t5_phase",  phase,  0);
        check("t5_state",  state,  2'b10);
        repeat (14) cycle();
        check("t5_req_cleared", green, 4'b0001);

        // 6: ticks stall mid-yellow; demand still latches
        car = 4'b0010; cycle();
        car = 4'b0000;
        wait_state(2'b01, 10, "t6_wait_yellow");
        cycle();
        tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            car = (i == 50) ? 4'b0100 : 4'b0000;
            cycle();
        end
        car = 4'b0000;
        check("t6_frozen_state",  state,  2'b01);
        check("t6_frozen_yellow", yellow, 4'b0001);
        tick = 1'b1; cycle();
        check("t6_resume_yellow", state, 2'b01);
        cycle();
        check("t6_resume_allred", state, 2'b10);
        repeat (2) cycle();
        check("t6_green1", green, 4'b0010);
        begin
            int n = 0;
            while (green !== 4'b0100 && n < 40) begin
                cycle();
                n++;
            end
            check("t6_latched_green2", green, 4'b0100);
        end

        // Randomized traffic, flash and occasional reset against the model
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 99) < 70);
            for (int p = 0; p < N; p++) car[p] = ($urandom_range(0, 99) < 8);
            if (!flash && $urandom_range(0, 299) == 0)      flash = 1'b1;
            else if (flash && $urandom_range(0, 29) == 0)   flash = 1'b0;
            nrst = ($urandom_range(0, 799) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_n.md
Name: traffic_light_ctrl_n

Overview:
Parametrised multi-phase traffic light controller. It replaces the fixed 4-state next-state block and its external short/long timers. The block integrates per-state tick counters, latched vehicle demand with round-robin phase skipping, green extension, and a maintenance flash mode. It sits between the timebase prescaler (Tick_i) and the lamp drivers.

Parameters:
NUM_PHASES, 4, number of conflicting approaches (>=2)
GREEN_MIN, 5, minimum green duration in ticks (>=1)
GREEN_MAX, 20, maximum green duration in ticks when extended (>=GREEN_MIN)
YELLOW_TIME, 3, yellow duration in ticks (>=1)
ALLRED_TIME, 2, all-red clearance duration in ticks (>=1)
CNT_W, 8, tick counter width; must hold GREEN_MAX-1

Ports:
Clk_i  in  1  clock; all state updates on rising edge
nReset_i  in  1  synchronous, active-low reset
Tick_i  in  1  one-cycle timebase enable; all timing is counted in ticks
Car_i  in  NUM_PHASES  vehicle-present sensor per phase (level)
Flash_i  in  1  maintenance flash request (level)
Green_o  out  NUM_PHASES  green lamp per phase
Yellow_o  out  NUM_PHASES  yellow lamp per phase
Red_o  out  NUM_PHASES  red lamp per phase
Phase_o  out  clog2(NUM_PHASES)  index of the current/last served phase
State_o  out  2  current state encoding

Behaviour:
- Interface: one clock Clk_i; nReset_i is synchronous and active-low.
- States: GREEN=2'b00, YELLOW=2'b01, ALLRED=2'b10, FLASH=2'b11.
- Registers: state, cur phase, cnt[CNT_W], req[NUM_PHASES], blink.
- Reset (nReset_i low at an edge): state=ALLRED, cur=0, cnt=0, req=0, blink=0.
  - Outputs after reset: Red_o=all 1, Green_o=0, Yellow_o=0, Phase_o=0, State_o=2'b10.
  - Reset overrides every other input and can occur in any state.
- Outputs are decoded from registered state only. There is no combinational input-to-output path.
  - Lamp changes are visible the cycle after the edge that changes state.
- Lamp decode:
  - GREEN: Green_o[cur]=1; all other phases red.
  - YELLOW: Yellow_o[cur]=1; all other phases red.
  - ALLRED: Red_o all 1.
  - FLASH: Red=0, Green=0, Yellow_o = all bits equal to blink.
- Counter:
  - Cleared on every state entry.
  - Changes only on cycles where Tick_i=1.
  - When Tick_i=0, state and cnt hold.
- Timed exits (evaluated on Tick_i):
  - YELLOW exits to ALLRED when cnt==YELLOW_TIME-1.
  - ALLRED exits to GREEN when cnt==ALLRED_TIME-1.
  - Otherwise cnt increments.
- GREEN exit: on Tick_i with other=|(req with bit cur masked), GREEN goes to YELLOW when all of the following hold:
  - cnt>=GREEN_MIN-1
  - other=1
  - Car_i[cur]==0 or cnt>=GREEN_MAX-1
  - Otherwise cnt increments, saturating at GREEN_MAX-1.
  - With no other demand, the block rests in GREEN indefinitely.
- Phase pick at the ALLRED->GREEN transition:
  - Search cyclically from cur+1 through cur, inclusive of cur last.
  - The first p with req[p]=1 becomes cur.
  - If req=0, cur is unchanged.
- Request latch:
  - req[p] is set on any cycle Car_i[p]=1, except while state==GREEN and cur==p.
  - req[p] is cleared on the edge that enters GREEN with cur=p. Clear wins over a simultaneous set.
  - Requests are independent of Tick_i.
- Flash mode:
  - Flash_i=1 at any edge in a non-FLASH state enters FLASH next cycle, regardless of Tick_i or cnt. cnt=0, blink=0.
  - In FLASH, blink toggles on each Tick_i.
  - Flash_i=0 at an edge in FLASH gives ALLRED with cnt=0 and blink=0. cur and req are kept.
- Phase_o = cur in all states.

Decomposition:
- Package tlc_pkg: state encoding constants, state typedef, phase-index width function (clog2).
- Sub-module tlc_phase_picker: purely combinational. Inputs req and cur; outputs next phase index and any_other flag.
- Timer, request latch and FSM stay in the top module.

Test Plan:
1. Reset, Tick_i=1 every cycle, Car_i=0 -> Red_o=4'b1111 for 2 ticks, then Green_o=4'b0001 held for 50+ ticks with Phase_o=0.
2. Phase 0 resting green; pulse Car_i=4'b0100 for 1 cycle -> green0 totals 5 ticks from entry, Yellow_o=4'b0001 for 3, all-red for 2, then Green_o=4'b0100 and Phase_o=2 (phase 1 skipped); req[2] clears.
3. Car_i[0] held 1; pulse Car_i[1] at green entry -> green0 lasts exactly 20 ticks, then yellow, all-red, Green_o=4'b0010.
4. Flash_i=1 mid-YELLOW of phase 1 -> next cycle State_o=3, Red_o=0, Yellow_o alternating 4'b0000/4'b1111 per tick. Release with req=0 -> 2 ticks all-red, then Green_o=4'b0010.
5. nReset_i low for one edge during GREEN of phase 3 with req=4'b0001 -> outputs at reset values next cycle, req=0, Phase_o=0.
6. Tick_i=0 for 100 cycles during YELLOW while Car_i[2] pulses -> state and lamps frozen, req[2]=1 latched. Ticks resume -> yellow completes its remaining count.
